// File: rtl/cache_match_pkg.sv
// Shared widths, counter limit and table entry layout
// for the ternary cache match stage.
package cache_match_pkg;

    localparam int DP_BIT    = 128;
    localparam int ENTRY_NUM = 16;
    localparam int IDX_W     = 4;
    localparam int ACT_W     = 16;
    localparam int CNT_W     = 32;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              vld;
        logic [DP_BIT-1:0] key;
        logic [DP_BIT-1:0] care;
        logic [ACT_W-1:0]  act;
    } entry_t;

endpackage

// File: rtl/cache_match_if.sv
// Key-in / result-out bundle between the extraction stage,
// the match stage and the forwarding logic.
interface cache_match_if #(
    parameter int IDX_W = cache_match_pkg::IDX_W
);
    import cache_match_pkg::*;

    logic [DP_BIT-1:0] i_dp_bit;
    logic              i_dp_bit_valid;
    logic [DP_BIT-1:0] i_dp_bit_mask;
    logic              o_result_valid;
    logic              o_hit;
    logic [IDX_W-1:0]  o_hit_idx;
    logic [ACT_W-1:0]  o_act;

    modport master (
        output i_dp_bit,
        output i_dp_bit_valid,
        output i_dp_bit_mask,
        input  o_result_valid,
        input  o_hit,
        input  o_hit_idx,
        input  o_act
    );

    modport slave (
        input  i_dp_bit,
        input  i_dp_bit_valid,
        input  i_dp_bit_mask,
        output o_result_valid,
        output o_hit,
        output o_hit_idx,
        output o_act
    );

endinterface

// File: rtl/cache_match_prio_enc.sv
// Lowest-index-wins priority encoder over the match vector.
module cache_match_prio_enc #(
    parameter int ENTRY_NUM = 16,
    parameter int IDX_W     = 4
) (
    input  logic [ENTRY_NUM-1:0] i_vec,
    output logic                 o_hit,
    output logic [IDX_W-1:0]     o_idx
);

    always_comb begin
        o_hit = |i_vec;
        o_idx = '0;
        for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
            if (i_vec[e]) o_idx = IDX_W'(e);
        end
    end

endmodule

// File: rtl/cache_match.sv
// Two-stage ternary lookup over a host-written table, with
// saturating per-entry hit counters readable by the host.
module cache_match #(
    parameter int ENTRY_NUM = cache_match_pkg::ENTRY_NUM,
    parameter int IDX_W     = cache_match_pkg::IDX_W,
    parameter int CNT_W     = cache_match_pkg::CNT_W
) (
    input  logic                               axis_clk,
    input  logic                               aresetn,
    cache_match_if.slave                       bus,
    input  logic                               i_cfg_wr_en,
    input  logic [IDX_W-1:0]                   i_cfg_wr_idx,
    input  logic [cache_match_pkg::DP_BIT-1:0] i_cfg_wr_key,
    input  logic [cache_match_pkg::DP_BIT-1:0] i_cfg_wr_care,
    input  logic [cache_match_pkg::ACT_W-1:0]  i_cfg_wr_act,
    input  logic                               i_cfg_wr_vld,
    input  logic [IDX_W-1:0]                   i_cnt_rd_idx,
    input  logic                               i_cnt_clr,
    output logic [CNT_W-1:0]                   o_cnt_rd_data
);
    import cache_match_pkg::*;

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(CNT_MAX);

    entry_t               tbl_q [ENTRY_NUM];
    entry_t               tbl_d [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] match;
    logic                 s1_vld_q, s1_vld_d;
    logic [ENTRY_NUM-1:0] s1_match_q, s1_match_d;
    logic [ACT_W-1:0]     s1_act_q [ENTRY_NUM];
    logic [ACT_W-1:0]     s1_act_d [ENTRY_NUM];
    logic                 enc_hit;
    logic [IDX_W-1:0]     enc_idx;
    logic                 res_vld_q, res_vld_d;
    logic                 hit_q, hit_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ACT_W-1:0]     act_q, act_d;
    logic [CNT_W-1:0]     cnt_q [ENTRY_NUM];
    logic [CNT_W-1:0]     cnt_d [ENTRY_NUM];
    logic [CNT_W-1:0]     rd_q, rd_d;

    always_comb begin
        tbl_d = tbl_q;
        if (i_cfg_wr_en) begin
            tbl_d[i_cfg_wr_idx].vld  = i_cfg_wr_vld;
            tbl_d[i_cfg_wr_idx].key  = i_cfg_wr_key;
            tbl_d[i_cfg_wr_idx].care = i_cfg_wr_care;
            tbl_d[i_cfg_wr_idx].act  = i_cfg_wr_act;
        end
    end

    // Compare uses the pre-write table, so a same-cycle write is not seen
    always_comb begin
        for (int e = 0; e < ENTRY_NUM; e++) begin
            match[e] = tbl_q[e].vld &&
                (((bus.i_dp_bit ^ tbl_q[e].key) & tbl_q[e].care
                  & bus.i_dp_bit_mask) == '0);
        end
    end

    always_comb begin
        s1_vld_d   = bus.i_dp_bit_valid;
        s1_match_d = match;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            s1_act_d[e] = tbl_q[e].act;
        end
    end

    cache_match_prio_enc #(
        .ENTRY_NUM (ENTRY_NUM),
        .IDX_W     (IDX_W)
    ) u_prio_enc (
        .i_vec (s1_match_q),
        .o_hit (enc_hit),
        .o_idx (enc_idx)
    );

    always_comb begin
        res_vld_d = s1_vld_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        act_d     = act_q;
        if (s1_vld_q) begin
            hit_d = enc_hit;
            idx_d = enc_hit ? enc_idx : '0;
            act_d = enc_hit ? s1_act_q[enc_idx] : '0;
        end
    end

    // Global clear beats per-entry write clear, which beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (s1_vld_q && enc_hit && cnt_q[enc_idx] != CMAX) begin
            cnt_d[enc_idx] = cnt_q[enc_idx] + CNT_W'(1);
        end
        if (i_cfg_wr_en) cnt_d[i_cfg_wr_idx] = '0;
        if (i_cnt_clr) begin
            for (int e = 0; e < ENTRY_NUM; e++) cnt_d[e] = '0;
        end
        rd_d = cnt_q[i_cnt_rd_idx];
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                tbl_q[e]    <= '0;
                s1_act_q[e] <= '0;
                cnt_q[e]    <= '0;
            end
            s1_vld_q   <= 1'b0;
            s1_match_q <= '0;
            res_vld_q  <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            act_q      <= '0;
            rd_q       <= '0;
        end else begin
            tbl_q      <= tbl_d;
            s1_act_q   <= s1_act_d;
            cnt_q      <= cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_match_q <= s1_match_d;
            res_vld_q  <= res_vld_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.o_result_valid = res_vld_q;
    assign bus.o_hit          = hit_q;
    assign bus.o_hit_idx      = idx_q;
    assign bus.o_act          = act_q;
    assign o_cnt_rd_data      = rd_q;

endmodule

// File: tb/tb_cache_match.sv
// Vector table plus scoreboard bench for cache_match, with
// short hand-written sequences for counter and reset corners.
module tb_cache_match;
    import cache_match_pkg::*;

    localparam int CW = 8;
    localparam logic [127:0] ONES = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_match_if #(.IDX_W(4)) bus();

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [127:0]  wr_key;
    logic [127:0]  wr_care;
    logic [15:0]   wr_act;
    logic          wr_vld;
    logic [3:0]    rd_idx;
    logic          cnt_clr;
    logic [CW-1:0] cnt_rd;

    cache_match #(
        .ENTRY_NUM (16),
        .IDX_W     (4),
        .CNT_W     (CW)
    ) dut (
        .axis_clk      (clk),
        .aresetn       (rst_n),
        .bus           (bus),
        .i_cfg_wr_en   (wr_en),
        .i_cfg_wr_idx  (wr_idx),
        .i_cfg_wr_key  (wr_key),
        .i_cfg_wr_care (wr_care),
        .i_cfg_wr_act  (wr_act),
        .i_cfg_wr_vld  (wr_vld),
        .i_cnt_rd_idx  (rd_idx),
        .i_cnt_clr     (cnt_clr),
        .o_cnt_rd_data (cnt_rd)
    );

    typedef struct {
        logic         wr;
        logic [3:0]   widx;
        logic [127:0] wkey;
        logic [127:0] wcare;
        logic [15:0]  wact;
        logic         wvld;
        logic         kv;
        logic [127:0] key;
        logic [127:0] mask;
        logic         eh;
        logic [3:0]   ei;
        logic [15:0]  ea;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        h;
        logic [3:0]  i;
        logic [15:0] a;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t got_e;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int strobes = 0;
    int snap;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t blank();
        vec_t v;
        v.wr = 0; v.widx = 0; v.wkey = 0; v.wcare = 0;
        v.wact = 0; v.wvld = 0; v.kv = 0; v.key = 0;
        v.mask = 0; v.eh = 0; v.ei = 0; v.ea = 0;
        return v;
    endfunction

    function automatic vec_t wv(input logic [3:0] i,
                                input logic [127:0] k,
                                input logic [127:0] c,
                                input logic [15:0] a,
                                input logic vd);
        vec_t v = blank();
        v.wr = 1; v.widx = i; v.wkey = k;
        v.wcare = c; v.wact = a; v.wvld = vd;
        return v;
    endfunction

    function automatic vec_t kvv(input logic [127:0] k,
                                 input logic [127:0] m,
                                 input logic h,
                                 input logic [3:0] i,
                                 input logic [15:0] a);
        vec_t v = blank();
        v.kv = 1; v.key = k; v.mask = m;
        v.eh = h; v.ei = i; v.ea = a;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk); #1;
        wr_en   = v.wr;   wr_idx = v.widx;
        wr_key  = v.wkey; wr_care = v.wcare;
        wr_act  = v.wact; wr_vld = v.wvld;
        bus.i_dp_bit_valid = v.kv;
        bus.i_dp_bit       = v.key;
        bus.i_dp_bit_mask  = v.mask;
        if (v.kv) sb.push_back('{cyc + 2, v.eh, v.ei, v.ea});
    endtask

    task automatic idle();
        drive(blank());
    endtask

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic rd(input logic [3:0] i,
                      input logic [CW-1:0] want,
                      input string nm);
        repeat (3) idle();
        @(posedge clk); #1;
        rd_idx = i;
        @(posedge clk); #1;
        chk(nm, 64'(cnt_rd), 64'(want));
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.o_result_valid) begin
            strobes++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL stray_strobe cyc=%0d got valid=1 want 0",
                         cyc);
            end else begin
                got_e = sb.pop_front();
                if (got_e.cyc != cyc || bus.o_hit !== got_e.h ||
                    bus.o_hit_idx !== got_e.i ||
                    bus.o_act !== got_e.a) begin
                    n_err++;
                    $display("FAIL result got cyc=%0d hit=%0b idx=%0d act=%h want cyc=%0d hit=%0b idx=%0d act=%h",
                             cyc, bus.o_hit, bus.o_hit_idx,
                             bus.o_act, got_e.cyc, got_e.h,
                             got_e.i, got_e.a);
                end
            end
        end
    end

    initial begin
        wr_en = 0; wr_idx = 0; wr_key = 0; wr_care = 0;
        wr_act = 0; wr_vld = 0; rd_idx = 0; cnt_clr = 0;
        bus.i_dp_bit = 0;
        bus.i_dp_bit_valid = 0;
        bus.i_dp_bit_mask = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.o_result_valid), 0);
        chk("rst_hit", 64'(bus.o_hit), 0);
        chk("rst_idx", 64'(bus.o_hit_idx), 0);
        chk("rst_act", 64'(bus.o_act), 0);
        chk("rst_cnt", 64'(cnt_rd), 0);
        rst_n = 1'b1;

        // 0..10: exact, wildcard priority, mask, collision
        vt.push_back(wv(3, 128'hA5, 128'hFF, 16'h1234, 1));
        vt.push_back(kvv(128'hA5, ONES, 1, 3, 16'h1234));
        vt.push_back(wv(1, 128'h0, 128'h0, 16'h0BAD, 1));
        vt.push_back(kvv(128'hA5, ONES, 1, 1, 16'h0BAD));
        vt.push_back(kvv(128'h5A, ONES, 1, 1, 16'h0BAD));
        vt.push_back(wv(1, 128'h0, 128'h0, 16'h0, 0));
        vt.push_back(kvv(128'h5A, ONES, 0, 0, 16'h0));
        vt.push_back(wv(2, 128'h0F, 128'hFF, 16'h2222, 1));
        vt.push_back(kvv(128'h00, 128'hF0, 1, 2, 16'h2222));
        vt.push_back(wv(4, 128'h77, ONES, 16'h4444, 1));
        vt[9].kv = 1; vt[9].key = 128'h77; vt[9].mask = ONES;
        vt.push_back(kvv(128'h77, ONES, 1, 4, 16'h4444));
        // 11..14: back-to-back
        vt.push_back(kvv(128'hA5, ONES, 1, 3, 16'h1234));
        vt.push_back(kvv(128'h33, ONES, 0, 0, 16'h0));
        vt.push_back(kvv(128'hA5, ONES, 1, 3, 16'h1234));
        vt.push_back(kvv(128'h0F, ONES, 1, 2, 16'h2222));
        // 15..17: act snapshot survives a write in flight
        vt.push_back(kvv(128'hA5, ONES, 1, 3, 16'h1234));
        vt.push_back(wv(3, 128'hA5, 128'hFF, 16'h9999, 1));
        vt.push_back(kvv(128'hA5, ONES, 1, 3, 16'h9999));

        for (int i = 0; i <= 10; i++) drive(vt[i]);
        rd(3, 1, "cnt3_after_a");
        rd(2, 1, "cnt2_after_a");
        rd(4, 1, "cnt4_after_a");
        rd(1, 0, "cnt1_wr_clr_wins");

        pulse_clr();
        rd(3, 0, "cnt3_after_clr");

        for (int i = 11; i <= 14; i++) drive(vt[i]);
        rd(3, 2, "cnt3_b2b");
        rd(2, 1, "cnt2_b2b");

        for (int i = 15; i <= 17; i++) drive(vt[i]);
        rd(3, 1, "cnt3_snap");

        pulse_clr();
        for (int i = 0; i < 254; i++) begin
            drive(kvv(128'hA5, ONES, 1, 3, 16'h9999));
        end
        rd(3, 254, "cnt3_max_m1");
        for (int i = 0; i < 3; i++) begin
            drive(kvv(128'hA5, ONES, 1, 3, 16'h9999));
        end
        rd(3, 255, "cnt3_sat");

        drive(kvv(128'hA5, ONES, 1, 3, 16'h9999));
        @(posedge clk); #1;
        bus.i_dp_bit_valid = 0;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        rd(3, 0, "cnt3_clr_vs_hit");

        drive(kvv(128'hA5, ONES, 1, 3, 16'h9999));
        drive(kvv(128'hA5, ONES, 1, 3, 16'h9999));
        #2;
        rst_n = 1'b0;
        sb.delete();
        bus.i_dp_bit_valid = 0;
        snap = strobes;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_strobe_after_rst", 64'(strobes), 64'(snap));

        drive(kvv(128'hA5, ONES, 0, 0, 16'h0));
        rd(3, 0, "cnt3_after_rst");

        repeat (4) idle();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_match.md
Name: cache_match

Overview:
- Consumes the 128-bit extracted key (plus per-bit mask) produced once per packet by the bit-extraction stage.
- Performs a ternary match against a host-configured table of cache entries and returns the lowest-index hit, its action word, or a miss.
- Keeps a saturating per-entry hit counter that the host can read back.
- Sits directly downstream of the extraction stage. Its result feeds the forwarding/absorb decision logic.

Parameters:
- DP_BIT, 128, key and mask width.
- ENTRY_NUM, 16, number of table entries (power of 2, 2..64).
- IDX_W, 4, log2(ENTRY_NUM).
- ACT_W, 16, action word width per entry.
- CNT_W, 32, hit counter width.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- i_dp_bit  in  DP_BIT  extracted key.
- i_dp_bit_valid  in  1  single-cycle key strobe.
- i_dp_bit_mask  in  DP_BIT  1 = key bit was extracted and is significant.
- i_cfg_wr_en  in  1  table write strobe.
- i_cfg_wr_idx  in  IDX_W  entry to write.
- i_cfg_wr_key  in  DP_BIT  entry key.
- i_cfg_wr_care  in  DP_BIT  1 = entry cares about this bit.
- i_cfg_wr_act  in  ACT_W  entry action.
- i_cfg_wr_vld  in  1  entry enable.
- i_cnt_rd_idx  in  IDX_W  counter read select.
- i_cnt_clr  in  1  clear all counters.
- o_result_valid  out  1  single-cycle result strobe.
- o_hit  out  1  1 = hit, 0 = miss (meaningful with o_result_valid).
- o_hit_idx  out  IDX_W  matching entry index (0 on miss).
- o_act  out  ACT_W  action of matching entry (0 on miss).
- o_cnt_rd_data  out  CNT_W  registered counter of i_cnt_rd_idx.

Behaviour:
- Reset (async assert, sync release):
  - All table entries are cleared: vld=0, key/care/act=0.
  - All counters are 0.
  - Pipeline valids are 0.
  - All outputs are 0.
- Entry e matches when:
  - vld[e]=1, and
  - ((i_dp_bit ^ key[e]) & care[e] & i_dp_bit_mask) == 0.
- An entry with care = 0 and vld = 1 is a wildcard and matches every key.
- Pipeline, fixed latency 2:
  - Cycle T: i_dp_bit_valid.
  - T+1: stage-1 register holds the ENTRY_NUM-bit match vector, the valid bit, and snapshots of act for all entries.
  - T+2: stage 2 priority-encodes (lowest index wins) and registers o_result_valid=1, o_hit, o_hit_idx, o_act.
  - o_result_valid is 0 in every other cycle. The other result outputs hold their last value.
- Throughput: a new key is accepted every cycle. There is no backpressure and no ready signal.
- Table write: takes effect at the clock edge of i_cfg_wr_en.
  - A key presented in the same cycle as a write compares against the old contents.
  - A key presented in the next cycle compares against the new contents.
  - The act returned is the one snapshotted at stage 1, so a write between T+1 and T+2 does not alter the in-flight result.
- Counters:
  - On a stage-2 hit, counter[o_hit_idx] increments by 1, saturating at all-ones (no wrap).
  - A table write to entry e clears counter[e] at the same edge. If that same edge carries a hit increment for e, the clear wins.
  - i_cnt_clr clears all counters and has priority over increments.
- o_cnt_rd_data = counter[i_cnt_rd_idx], registered, 1-cycle read latency. It reflects the counter value after the previous edge.
- Reset mid-operation: in-flight lookups are discarded and no result strobe is emitted after reset release.

Decomposition:
- Package cache_match_pkg holds:
  - DP_BIT, ENTRY_NUM, IDX_W, ACT_W, CNT_W defaults.
  - The CNT_MAX constant.
  - The entry record layout: vld, key, care, act.
- Sub-module cache_match_prio_enc (combinational, parameterised on ENTRY_NUM) returns hit and lowest set index. It is instantiated in stage 2.
- Table storage, compare array, counters and pipeline registers live in cache_match.

Test Plan:
- Exact hit: write idx 3 with key=128'hA5, care=128'hFF, act=16'h1234, vld=1. Present key 128'hA5, mask all-ones. Required: at T+2, o_hit=1, o_hit_idx=3, o_act=16'h1234; counter[3] reads 1.
- Priority and wildcard:
  - Add idx 1 with care=0, act=16'h0BAD, vld=1.
  - Present key 128'hA5. Required: hit idx 1, act 16'h0BAD.
  - Present key 128'h5A. Required: hit idx 1.
  - Clear idx 1 (vld=0) and present key 128'h5A. Required: o_hit=0, o_hit_idx=0, o_act=0.
- Mask don't-care: entry idx 2 with key=128'h0F, care=128'hFF. Present key 128'h00 with mask=128'hF0. Required: hit idx 2 (low nibble ignored by the key mask).
- Write/lookup collision:
  - Write idx 4 with key=128'h77, care=all-ones, vld=1, in the same cycle as key 128'h77 is presented. Required: miss.
  - Present the same key in the next cycle. Required: hit idx 4.
- Back-to-back: present 4 keys on consecutive cycles (hit 3, miss, hit 3, hit 2). Required:
  - 4 consecutive o_result_valid strobes, in order, starting at T+2.
  - counter[3]=2, counter[2]=1.
- Counter saturation and clear:
  - Force counter[3] to CNT_MAX-1, then send 3 hits. Required: counter reads CNT_MAX.
  - Assert i_cnt_clr together with a hit. Required: the counter reads 0.
  - Assert aresetn=0 mid-pipeline. Required: no result strobe after release.
